// File: rtl/breakout_ball_if.sv
// rtl/breakout_ball_if.sv - collision bus between the ball controller and the block-column checkers
interface breakout_ball_if;
    logic        moveU;
    logic        moveD;
    logic        moveL;
    logic        moveR;
    logic [10:0] ball_x_l;
    logic [10:0] ball_x_r;
    logic [10:0] ball_y_t;
    logic [10:0] ball_y_b;

    modport master (
        input  moveU, moveD, moveL, moveR,
        output ball_x_l, ball_x_r, ball_y_t, ball_y_b
    );

    modport slave (
        output moveU, moveD, moveL, moveR,
        input  ball_x_l, ball_x_r, ball_y_t, ball_y_b
    );
endinterface

// File: rtl/breakout_ball.sv
// rtl/breakout_ball.sv - Breakout ball motion, bounce resolution, serve/miss sequencing and lives
module breakout_ball #(
    parameter int H_MAX      = 799,
    parameter int V_MAX      = 599,
    parameter int BALL_SIZE  = 8,
    parameter int SPEED      = 2,
    parameter int PADDLE_X_L = 760,
    parameter int PADDLE_H   = 80,
    parameter int START_X    = 700,
    parameter int START_Y    = 296,
    parameter int LIVES      = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   refresh_tick,
    input  logic                   serve,
    input  logic [10:0]            paddle_y_t,
    input  logic [10:0]            pix_x,
    input  logic [10:0]            pix_y,
    breakout_ball_if.master        bus,
    output logic                   ball_on,
    output logic [1:0]             lives,
    output logic                   miss,
    output logic                   game_over
);
    localparam logic [10:0] SPD     = 11'(SPEED);
    localparam logic [10:0] EDGE    = 11'(BALL_SIZE - 1);
    localparam logic [10:0] HMAX    = 11'(H_MAX);
    localparam logic [10:0] BOT_LIM = 11'(V_MAX - SPEED);
    localparam logic [10:0] Y_LIM   = 11'(V_MAX - BALL_SIZE + 1);
    localparam logic [10:0] PXL     = 11'(PADDLE_X_L);
    localparam logic [10:0] PHM     = 11'(PADDLE_H - 1);
    localparam logic [10:0] SX      = 11'(START_X);
    localparam logic [10:0] SY      = 11'(START_Y);
    localparam logic [1:0]  LV      = 2'(LIVES);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t      state;
    logic [10:0] x_l, y_t, x_r, y_b;
    logic        dir_x, dir_y;        // 1 = right / down
    logic        p_u, p_d, p_l, p_r;

    logic        e_u, e_d, e_l, e_r;
    logic        paddle_hit;
    logic        nx_dir_x, nx_dir_y;
    logic [10:0] nx_x_l, nx_y_t, nx_x_r;

    assign x_r = x_l + EDGE;
    assign y_b = y_t + EDGE;

    assign bus.ball_x_l = x_l;
    assign bus.ball_x_r = x_r;
    assign bus.ball_y_t = y_t;
    assign bus.ball_y_b = y_b;

    assign ball_on = (state != OVER) && (pix_x >= x_l) && (pix_x <= x_r)
                     && (pix_y >= y_t) && (pix_y <= y_b);

    // A request arriving with the tick is consumed by that same tick.
    assign e_u = p_u | bus.moveU;
    assign e_d = p_d | bus.moveD;
    assign e_l = p_l | bus.moveL;
    assign e_r = p_r | bus.moveR;

    always_comb begin
        paddle_hit = dir_x && (x_r >= PXL - SPD) && (x_r <= PXL)
                     && (y_b >= paddle_y_t) && (y_t <= paddle_y_t + PHM);

        nx_dir_x = dir_x;
        if (e_r)             nx_dir_x = 1'b1;
        else if (e_l)        nx_dir_x = 1'b0;
        else if (x_l <= SPD) nx_dir_x = 1'b1;
        else if (paddle_hit) nx_dir_x = 1'b0;

        nx_dir_y = dir_y;
        if (e_d)                 nx_dir_y = 1'b1;
        else if (e_u)            nx_dir_y = 1'b0;
        else if (y_t <= SPD)     nx_dir_y = 1'b1;
        else if (y_b >= BOT_LIM) nx_dir_y = 1'b0;

        if (nx_dir_x)       nx_x_l = x_l + SPD;
        else if (x_l < SPD) nx_x_l = 11'd0;
        else                nx_x_l = x_l - SPD;

        if (nx_dir_y)              nx_y_t = (y_t >= Y_LIM - SPD) ? Y_LIM : y_t + SPD;
        else if (y_t < SPD)        nx_y_t = 11'd0;
        else                       nx_y_t = y_t - SPD;

        nx_x_r = nx_x_l + EDGE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x_l       <= SX;
            y_t       <= SY;
            dir_x     <= 1'b0;
            dir_y     <= 1'b0;
            p_u       <= 1'b0;
            p_d       <= 1'b0;
            p_l       <= 1'b0;
            p_r       <= 1'b0;
            lives     <= LV;
            miss      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            miss <= 1'b0;
            case (state)
                IDLE: begin
                    p_u <= 1'b0;
                    p_d <= 1'b0;
                    p_l <= 1'b0;
                    p_r <= 1'b0;
                    if (serve) begin
                        state <= PLAY;
                        dir_x <= 1'b0;
                        dir_y <= 1'b0;
                    end
                end
                PLAY: begin
                    if (refresh_tick) begin
                        p_u <= 1'b0;
                        p_d <= 1'b0;
                        p_l <= 1'b0;
                        p_r <= 1'b0;
                        if (nx_x_r >= HMAX) begin
                            miss  <= 1'b1;
                            x_l   <= SX;
                            y_t   <= SY;
                            dir_x <= 1'b0;
                            dir_y <= 1'b0;
                            if (lives != 2'd0) lives <= lives - 2'd1;
                            if (lives <= 2'd1) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            x_l   <= nx_x_l;
                            y_t   <= nx_y_t;
                            dir_x <= nx_dir_x;
                            dir_y <= nx_dir_y;
                        end
                    end else begin
                        p_u <= e_u;
                        p_d <= e_d;
                        p_l <= e_l;
                        p_r <= e_r;
                    end
                end
                OVER: begin
                    game_over <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
